// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution stage of the monocycle core.
// Resolves branch/jump redirects and keeps a sticky misaligned flag and a saturating redirect count.
module pc_branch_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 branch_i,
  input  logic                 jal_i,
  input  logic                 jalr_i,
  input  logic [2:0]           funct3_i,
  input  logic                 equal_i,
  input  logic                 lesser_s_i,
  input  logic                 lesser_u_i,
  input  logic [WIDTH-1:0]     imm_i,
  input  logic [WIDTH-1:0]     rs1_i,
  output logic [WIDTH-1:0]     pc_o,
  output logic [WIDTH-1:0]     pc_plus4_o,
  output logic                 taken_o,
  output logic [WIDTH-1:0]     target_o,
  output logic                 misaligned_o,
  output logic [CNT_WIDTH-1:0] taken_count_o
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic             cond;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] pc_rel;
  logic             target_misaligned;
  logic             update;
  logic             cnt_full;

  // Branch condition decode; reserved codes never take
  always_comb begin
    cond = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  cond = equal_i;
      F3_BNE:  cond = !equal_i;
      F3_BLT:  cond = lesser_s_i;
      F3_BGE:  cond = !lesser_s_i;
      F3_BLTU: cond = lesser_u_i;
      F3_BGEU: cond = !lesser_u_i;
      default: cond = 1'b0;
    endcase
  end

  // Target selection: JALR dominates, JAL and branches share the PC-relative adder
  always_comb begin
    jalr_sum = rs1_i + imm_i;
    pc_rel   = pc_o + imm_i;
    taken_o  = jalr_i | jal_i | (branch_i & cond);
    if (jalr_i) begin
      target_o = {jalr_sum[WIDTH-1:1], 1'b0};
    end else begin
      target_o = pc_rel;
    end
    target_misaligned = taken_o & (target_o[1:0] != 2'b00);
  end

  assign pc_plus4_o = pc_o + WIDTH'(4);
  assign cnt_full   = &taken_count_o;
  // A pending clear releases the freeze within the same cycle
  assign update     = enable_i & (!misaligned_o | clear_i);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pc_o          <= RESET_PC;
      misaligned_o  <= 1'b0;
      taken_count_o <= '0;
    end else begin
      if (clear_i) begin
        misaligned_o  <= 1'b0;
        taken_count_o <= '0;
      end
      if (update) begin
        if (!taken_o) begin
          pc_o <= pc_plus4_o;
        end else if (!target_misaligned) begin
          pc_o <= target_o;
          if (!clear_i && !cnt_full) begin
            taken_count_o <= taken_count_o + CNT_WIDTH'(1);
          end
        end else if (!clear_i) begin
          misaligned_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit (RESET_PC=0x100, 2-bit counter).
module tb_pc_branch_unit;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        clear;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [2:0]  funct3;
  logic        equal;
  logic        lesser_s;
  logic        lesser_u;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic [31:0] target;
  logic        misaligned;
  logic [1:0]  taken_count;

  int checks;
  int errors;

  pc_branch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0100),
    .CNT_WIDTH(2)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .enable_i     (enable),
    .clear_i      (clear),
    .branch_i     (branch),
    .jal_i        (jal),
    .jalr_i       (jalr),
    .funct3_i     (funct3),
    .equal_i      (equal),
    .lesser_s_i   (lesser_s),
    .lesser_u_i   (lesser_u),
    .imm_i        (imm),
    .rs1_i        (rs1),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .taken_o      (taken),
    .target_o     (target),
    .misaligned_o (misaligned),
    .taken_count_o(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    branch = 0; jal = 0; jalr = 0; funct3 = 3'b010;
    equal = 0; lesser_s = 0; lesser_u = 0; imm = '0; rs1 = '0; clear = 0;
  endtask

  task automatic do_clear();
    idle_ctrl();
    enable = 0; clear = 1;
    step();
    clear = 0;
  endtask

  task automatic jump_by(input logic [31:0] off);
    idle_ctrl();
    enable = 1; jal = 1; imm = off;
    step();
    jal = 0;
  endtask

  task automatic test_reset();
    idle_ctrl();
    enable = 0; resetn = 0;
    #12;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL reset_pc4 got %h exp %h", pc_plus4, 32'h104); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misaligned); end
    checks++; if (taken_count !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", taken_count); end
    @(negedge clk); resetn = 1;
    enable = 1;
    repeat (3) step();
    checks++; if (pc !== 32'h10C) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'h10C); end
  endtask

  task automatic test_bge();
    jump_by(32'h0000_00F4);  // 0x10C -> 0x200
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL bge_setup got %h exp %h", pc, 32'h200); end
    do_clear();
    enable = 1; branch = 1; funct3 = 3'b101; lesser_s = 0; imm = 32'hFFFF_FFF0;
    #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL bge_taken got %b exp 1", taken); end
    checks++; if (target !== 32'h1F0) begin errors++; $display("FAIL bge_target got %h exp %h", target, 32'h1F0); end
    step();
    checks++; if (pc !== 32'h1F0) begin errors++; $display("FAIL bge_pc got %h exp %h", pc, 32'h1F0); end
    checks++; if (taken_count !== 2'd1) begin errors++; $display("FAIL bge_cnt got %0d exp 1", taken_count); end
    jump_by(32'h0000_0010);  // 0x1F0 -> 0x200, count 2
    enable = 1; branch = 1; funct3 = 3'b101; lesser_s = 1; imm = 32'hFFFF_FFF0;
    #1;
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bge_nt_taken got %b exp 0", taken); end
    step();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL bge_nt_pc got %h exp %h", pc, 32'h204); end
    checks++; if (taken_count !== 2'd2) begin errors++; $display("FAIL bge_nt_cnt got %0d exp 2", taken_count); end
    idle_ctrl();
  endtask

  task automatic test_conditions();
    logic [2:0] f3  [12] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101,
                             3'b110, 3'b110, 3'b111, 3'b111, 3'b010, 3'b011};
    logic       eq  [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    logic       ls  [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
    logic       lu  [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
    logic       exp [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    idle_ctrl();
    enable = 0; branch = 1;
    for (int i = 0; i < 12; i++) begin
      funct3 = f3[i]; equal = eq[i]; lesser_s = ls[i]; lesser_u = lu[i];
      #1;
      checks++; if (taken !== exp[i]) begin errors++; $display("FAIL cond_%0d got %b exp %b", i, taken, exp[i]); end
    end
    idle_ctrl();
  endtask

  task automatic test_jalr_priority();
    do_clear();
    enable = 0; jalr = 1; rs1 = 32'h1002; imm = 32'h3;
    #1;
    checks++; if (target !== 32'h1004) begin errors++; $display("FAIL jalr_bit0 got %h exp %h", target, 32'h1004); end
    jalr = 1; branch = 1; funct3 = 3'b000; equal = 1; rs1 = 32'h1001; imm = 32'h3;
    enable = 1;
    #1;
    checks++; if (target !== 32'h1004) begin errors++; $display("FAIL jalr_target got %h exp %h", target, 32'h1004); end
    step();
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL jalr_pc got %h exp %h", pc, 32'h1004); end
    checks++; if (taken_count !== 2'd1) begin errors++; $display("FAIL jalr_cnt got %0d exp 1", taken_count); end
    idle_ctrl();
  endtask

  task automatic test_misaligned();
    jump_by(32'hFFFF_F2FC);  // 0x1004 -> 0x300
    do_clear();
    enable = 1; jal = 1; imm = 32'h6;
    #1;
    checks++; if (target !== 32'h306) begin errors++; $display("FAIL mis_target got %h exp %h", target, 32'h306); end
    step();
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_set got %b exp 1", misaligned); end
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL mis_pc got %h exp %h", pc, 32'h300); end
    jal = 0;  // not-taken would advance if not frozen
    repeat (3) step();
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL mis_frozen got %h exp %h", pc, 32'h300); end
    checks++; if (taken_count !== 2'd0) begin errors++; $display("FAIL mis_cnt got %0d exp 0", taken_count); end
    clear = 1;
    step();
    clear = 0;
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misaligned); end
    checks++; if (pc !== 32'h304) begin errors++; $display("FAIL mis_resume got %h exp %h", pc, 32'h304); end
    clear = 1; jal = 1; imm = 32'h6;
    step();
    clear = 0; jal = 0;
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL clr_wins got %b exp 0", misaligned); end
    checks++; if (pc !== 32'h304) begin errors++; $display("FAIL clr_hold got %h exp %h", pc, 32'h304); end
    idle_ctrl();
  endtask

  task automatic test_wrap_stall();
    jump_by(32'hFFFF_FCF8);  // 0x304 -> 0xFFFF_FFFC, count 1
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp %h", pc, 32'hFFFF_FFFC); end
    idle_ctrl(); enable = 1;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
    enable = 0; branch = 1; funct3 = 3'b000; equal = 1; imm = 32'h40;
    repeat (5) step();
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL stall_taken got %b exp 1", taken); end
    checks++; if (target !== 32'h40) begin errors++; $display("FAIL stall_target got %h exp %h", target, 32'h40); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL stall_pc got %h exp %h", pc, 32'h0); end
    checks++; if (taken_count !== 2'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", taken_count); end
    idle_ctrl();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_clear();
    enable = 1; branch = 1; funct3 = 3'b000; equal = 1; imm = 32'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (taken_count !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", i, taken_count, exp_cnt[i]); end
    end
    checks++; if (pc !== 32'h28) begin errors++; $display("FAIL sat_pc got %h exp %h", pc, 32'h28); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    resetn = 0;
    #1;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL areset_pc got %h exp %h", pc, 32'h100); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL areset_pc4 got %h exp %h", pc_plus4, 32'h104); end
    checks++; if (taken_count !== 2'd0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", taken_count); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL areset_mis got %b exp 0", misaligned); end
    idle_ctrl();
    @(negedge clk); resetn = 1;
    enable = 1;
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL post_reset got %h exp %h", pc, 32'h104); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 0;
    enable = 0;
    idle_ctrl();
    test_reset();
    test_bge();
    test_conditions();
    test_jalr_priority();
    test_misaligned();
    test_wrap_stall();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
